vmem_write_buffer: RTL

//  Downstream of the CPU core: captures video-memory stores (mem_addr, b, vmem_we).

---
 rtl/vmem_pkg.sv | 15 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/vmem_write_buffer.sv | 78 +++++++
 3 files changed

// File: rtl/vmem_pkg.sv
// rtl/vmem_pkg.sv - shared widths for the video-memory write buffer
package vmem_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 16;
    localparam int VADDR_W = 12;
    localparam int DEPTH   = 8;
    localparam int ENTRY_W = VADDR_W + DATA_W;

    typedef struct packed {
        logic [VADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
    } vmem_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - register-array FIFO; a push into a full FIFO is taken only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       pop_fire,
    output logic                       drop,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             push_fire;

    // Pop is decided on the pre-edge level, so a push into an empty FIFO never bypasses.
    always_comb begin
        empty     = (level == '0);
        full      = (level == LVL_W'(DEPTH));
        pop_fire  = pop && !empty;
        push_fire = push && (!full || pop_fire);
        drop      = push && !push_fire;
        pop_data  = mem[rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/vmem_write_buffer.sv
// rtl/vmem_write_buffer.sv - queues CPU video stores and drains them on scanner grants
module vmem_write_buffer
    import vmem_pkg::*;
#(
    parameter int DATA_W  = vmem_pkg::DATA_W,
    parameter int ADDR_W  = vmem_pkg::ADDR_W,
    parameter int VADDR_W = vmem_pkg::VADDR_W,
    parameter int DEPTH   = vmem_pkg::DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_we,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_data,
    input  logic                   vram_grant,
    input  logic                   ovf_clr,
    output logic                   vram_we,
    output logic [VADDR_W-1:0]     vram_addr,
    output logic [DATA_W-1:0]      vram_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   overflow
);

    localparam int E_W = VADDR_W + DATA_W;

    logic [E_W-1:0] push_entry;
    logic [E_W-1:0] head_entry;
    logic           pop_fire;
    logic           drop;
    logic           unused_addr_hi;

    // Only the VRAM-sized low address bits are meaningful downstream.
    assign push_entry     = {cpu_addr[VADDR_W-1:0], cpu_data};
    assign unused_addr_hi = ^cpu_addr[ADDR_W-1:VADDR_W];

    sync_fifo #(
        .WIDTH (E_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (cpu_we),
        .push_data (push_entry),
        .pop       (vram_grant),
        .pop_data  (head_entry),
        .pop_fire  (pop_fire),
        .drop      (drop),
        .level     (level),
        .full      (full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            vram_we   <= 1'b0;
            vram_addr <= '0;
            vram_data <= '0;
        end else if (pop_fire) begin
            vram_we   <= 1'b1;
            vram_addr <= head_entry[E_W-1:DATA_W];
            vram_data <= head_entry[DATA_W-1:0];
        end else begin
            vram_we   <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
